// File: rtl/inst_encoder.sv
// Streaming RV32 instruction encoder with a 2-entry output buffer and sequential word addresses.
// Optional immediate range check: define INST_ENCODER_RANGE_CHECK_EN.
module inst_encoder #(
    parameter int unsigned DEPTH     = 2,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  in_opcode,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [2:0]  in_funct3,
    input  logic [6:0]  in_funct7,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_addr,
    output logic        err_sticky,
    output logic [7:0]  err_count
);

`ifdef INST_ENCODER_RANGE_CHECK_EN
    localparam bit RANGE_EN = 1'b1;
`else
    localparam bit RANGE_EN = 1'b0;
`endif

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_ARITHI = 7'b0010011;
    localparam logic [6:0] OP_ARITH  = 7'b0110011;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic        [31:0] r_inst [2];
    logic        [31:0] r_waddr [2];
    logic               r_head;
    logic        [31:0] r_addr;
    logic               r_err_sticky;
    logic        [7:0]  r_err_count;

    logic        [31:0] w_word;
    logic               w_fmt_ok;
    logic               w_fits;
    logic               w_word_ok;
    logic signed [31:0] w_imm_s;
    logic        [1:0]  w_count;
    logic               w_accept;
    logic               w_push;
    logic               w_reject;
    logic               w_pop;
    logic               w_tail;

    assign w_imm_s = in_imm;

    always_comb begin
        w_word   = '0;
        w_fmt_ok = 1'b1;
        w_fits   = 1'b1;
        case (in_opcode)
            OP_ARITH: w_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
            OP_LOAD, OP_ARITHI, OP_JALR: begin
                w_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
                w_fits = (w_imm_s >= -32'sd2048) && (w_imm_s <= 32'sd2047);
            end
            OP_STORE: begin
                w_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
                w_fits = (w_imm_s >= -32'sd2048) && (w_imm_s <= 32'sd2047);
            end
            OP_BRANCH: begin
                w_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                          in_imm[4:1], in_imm[11], in_opcode};
                w_fits = (w_imm_s >= -32'sd4096) && (w_imm_s <= 32'sd4094) && !in_imm[0];
            end
            OP_JAL: begin
                w_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
                w_fits = (w_imm_s >= -32'sd1048576) && (w_imm_s <= 32'sd1048574) && !in_imm[0];
            end
            default: w_fmt_ok = 1'b0;
        endcase
    end

    assign w_word_ok = w_fmt_ok && (w_fits || !RANGE_EN);
    assign w_count   = r_state;
    assign in_ready  = (w_count < 2'(DEPTH)) && !clear;
    assign out_valid = (r_state != S_EMPTY);
    assign w_accept  = in_valid && in_ready;
    assign w_push    = w_accept && w_word_ok;
    assign w_reject  = w_accept && !w_word_ok;
    assign w_pop     = out_valid && out_ready && !clear;
    // With one entry held the tail is the other slot; when empty it aliases the head.
    assign w_tail    = r_head ^ (r_state == S_ONE);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_EMPTY: if (w_push) w_state_nxt = S_ONE;
            S_ONE: begin
                if (w_push && !w_pop)      w_state_nxt = S_FULL;
                else if (w_pop && !w_push) w_state_nxt = S_EMPTY;
            end
            S_FULL:  if (w_pop) w_state_nxt = S_ONE;
            default: w_state_nxt = S_EMPTY;
        endcase
        if (clear) w_state_nxt = S_EMPTY;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_EMPTY;
            r_head       <= 1'b0;
            r_addr       <= BASE_ADDR;
            r_err_sticky <= 1'b0;
            r_err_count  <= '0;
            for (int unsigned i = 0; i < 2; i++) begin
                r_inst[i]  <= '0;
                r_waddr[i] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            if (clear) begin
                r_head       <= 1'b0;
                r_addr       <= BASE_ADDR;
                r_err_sticky <= 1'b0;
            end else begin
                if (w_push) begin
                    r_inst[w_tail]  <= w_word;
                    r_waddr[w_tail] <= r_addr;
                    r_addr          <= r_addr + 32'd4;
                end
                if (w_pop) r_head <= ~r_head;
                if (w_reject) begin
                    r_err_sticky <= 1'b1;
                    if (r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
                end
            end
        end
    end

    assign out_inst   = out_valid ? r_inst[r_head]  : '0;
    assign out_addr   = out_valid ? r_waddr[r_head] : BASE_ADDR;
    assign err_sticky = r_err_sticky;
    assign err_count  = r_err_count;

endmodule

// File: doc/inst_encoder.md
# inst_encoder

Streaming RV32 instruction encoder: accepts instruction fields (opcode, register indices, funct fields, signed 32-bit immediate) over a valid/ready handshake. It packs them into 32-bit instruction words in the format the immediate generator expects, and queues them in a 2-entry buffer for writing into instruction memory. Each emitted word carries a sequential word-aligned address. The block feeds the instruction-memory load port during test/boot and is the inverse of the decode-side immediate extraction.

## Interface
Parameters:
- DEPTH, 2, output buffer entries (fixed at 2; count width 2 bits)
- BASE_ADDR, 32'h0, address assigned to the first word after reset or clear

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous: empty buffer, address counter to BASE_ADDR, clear err_sticky
- in_valid  in  1  field bundle valid
- in_ready  out  1  block can accept a bundle this cycle
- in_opcode  in  7  one of JAL, JALR, BRANCH(1100011), LOAD(0000011), STORE(0100011), ARITH_IMM(0010011), ARITH(0110011)
- in_rd, in_rs1, in_rs2  in  5 each  register indices
- in_funct3  in  3; in_funct7  in  7
- in_imm  in  32  signed immediate (byte offset for B/J)
- out_valid  out  1  head word valid
- out_ready  in  1  consumer takes head word
- out_inst  out  32  encoded instruction
- out_addr  out  32  instruction memory byte address of out_inst
- err_sticky  out  1  an input was rejected since reset/clear
- err_count  out  8  rejected-input count, saturating at 255

## Operation
- Packing by opcode class: R (ARITH) {funct7,rs2,rs1,funct3,rd,op}; I (LOAD, ARITH_IMM, JALR) {imm[11:0],rs1,funct3,rd,op}; S {imm[11:5],rs2,rs1,funct3,imm[4:0],op}; B {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],op}; J {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}. Fields not in the format are ignored.
- Acceptance: a transfer occurs when in_valid && in_ready. in_ready = (count < 2) && !clear.
- Reject: an unsupported opcode is always rejected. With the range-check feature enabled, an out-of-range immediate is also rejected. A rejected transfer is accepted (consumed) but not enqueued. It sets err_sticky and increments err_count (saturating). The address counter does not advance.
- Enqueue: a valid accepted word is written at the tail with the current address counter. The counter then advances by 4 and wraps modulo 2^32.
- Dequeue: occurs when out_valid && out_ready. The head advances.
- Simultaneous push and pop at count 1: count stays 1, and the new word becomes head after the edge.
- At count 2, in_ready is low, so a push cannot coincide with count 2.
- clear overrides push and pop in the same cycle. err_count is not affected by clear.
- Buffer states: EMPTY (count 0), ONE (1), FULL (2). EMPTY→ONE on push. ONE→FULL on push without pop. ONE→EMPTY on pop without push. FULL→ONE on pop. Any state→EMPTY on clear.

## Timing
- Reset values: in_ready 1, out_valid 0, out_inst 0, out_addr BASE_ADDR, err_sticky 0, err_count 0; address counter BASE_ADDR; count 0.
- Latency: a bundle accepted at edge N is visible on out_inst/out_addr with out_valid high from after edge N (registered). There is no combinational path from in_* to out_*.
- in_ready is a function of registered count and clear only. It does not depend combinationally on out_ready.
- out_inst/out_addr are held stable while out_valid && !out_ready.
- reset_n assertion mid-stream: all buffered words are dropped immediately and asynchronously. Outputs take their reset values.

## Configuration
- INST_ENCODER_RANGE_CHECK_EN defined: the immediate is rejected unless it fits its field.
  - I/S: −2048..2047.
  - B: −4096..4094 with imm[0]=0.
  - J: −1048576..1048574 with imm[0]=0.
- Undefined: the immediate is silently truncated to its field bits and never rejected. Only an unsupported opcode raises an error.

## Test plan
- ADDI (op 0010011, f3 0) rd=1, rs1=0, imm=5 → out_inst 0x00500093, out_addr 0x0, one cycle after accept.
- STORE f3=010, rs1=1, rs2=2, imm=8, then JAL rd=1, imm=8 → 0x0020A423 @0x0, then 0x008000EF @0x4.
- BRANCH f3=000, rs1=rs2=0, imm=−4 → 0xFE000EE3. Same with imm=−3 under RANGE_CHECK_EN → rejected, err_sticky=1, err_count=1, next valid word gets the unadvanced address.
- out_ready held 0, push 3 bundles → in_ready low after 2 accepts, third held. Raise out_ready → words drain in order with addresses 0x0, 0x4, then the third is accepted.
- Without RANGE_CHECK_EN, ADDI imm=2048 → 0x80000013 (truncated), no error. Opcode 1111111 → rejected, err_count increments.
- clear asserted with 2 words buffered → out_valid 0 next cycle, next word gets address BASE_ADDR, err_sticky 0, err_count kept. reset_n pulsed mid-transfer → all outputs return to reset values asynchronously.
